// File: rtl/serial_paralelo_pkg.sv
// Shared constants for the serial-to-parallel word receiver: default comma
// character, lock threshold and the receiver state encoding.
package serial_paralelo_pkg;

    // Idle/alignment character, transmitted MSB first.
    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

    // Consecutive aligned commas needed before the receiver declares lock.
    localparam int unsigned NUM_COMMA_DEFAULT = 4;

    localparam int unsigned WORD_W  = 8;
    localparam int unsigned STATE_W = 2;

    // Receiver states.
    localparam logic [STATE_W-1:0] SEARCH = 2'd0;
    localparam logic [STATE_W-1:0] SYNC   = 2'd1;
    localparam logic [STATE_W-1:0] ACTIVE = 2'd2;

endpackage

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver with comma-based word alignment.
// Hunts bit by bit for COMMA, confirms NUM_COMMA aligned commas, then emits
// one 9-bit word per 8 clk8f cycles.
//
// Ports:
//   clk8f       in   bit clock, all logic on its rising edge
//   reset       in   synchronous, active-high reset
//   serial      in   serial bit stream, 8-bit words, MSB first
//   paralelo    out  recovered word: [8] valid, [7:0] data (commas -> 9'h000)
//   word_strobe out  one-cycle pulse on every paralelo update
//   active      out  high while locked to word boundaries
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter logic [7:0]  COMMA     = COMMA_DEFAULT,
    parameter int unsigned NUM_COMMA = NUM_COMMA_DEFAULT
) (
    input  logic       clk8f,
    input  logic       reset,
    input  logic       serial,
    output logic [8:0] paralelo,
    output logic       word_strobe,
    output logic       active
);

    localparam int unsigned CNT_W = $clog2(NUM_COMMA + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_COMMA);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [WORD_W-1:0]  window;
    logic [WORD_W-1:0]  window_next;
    logic [2:0]         bit_cnt;
    logic [2:0]         bit_cnt_next;
    logic [CNT_W-1:0]   comma_cnt;
    logic [CNT_W-1:0]   comma_cnt_next;
    logic [8:0]         paralelo_next;
    logic               word_strobe_next;
    logic               active_next;
    logic               boundary;
    logic               is_comma;

    // Next-state and next-output logic.
    always_comb begin
        window_next      = {window[WORD_W-2:0], serial};
        state_next       = state;
        bit_cnt_next     = bit_cnt + 3'd1;
        comma_cnt_next   = comma_cnt;
        paralelo_next    = paralelo;
        word_strobe_next = 1'b0;
        boundary         = (bit_cnt == 3'd7);
        is_comma         = (window_next == COMMA);

        case (state)
            SEARCH: begin
                // Bit counter is held at 0 so it starts fresh on alignment.
                bit_cnt_next = 3'd0;
                if (is_comma) begin
                    comma_cnt_next = CNT_ONE;
                    state_next     = (NUM_COMMA <= 32'd1) ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (is_comma) begin
                        // Lock-completing comma changes state only; no strobe.
                        if (comma_cnt >= CNT_MAX - CNT_ONE) begin
                            comma_cnt_next = CNT_MAX;
                            state_next     = ACTIVE;
                        end else begin
                            comma_cnt_next = comma_cnt + CNT_ONE;
                        end
                    end else begin
                        comma_cnt_next = '0;
                        state_next     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    word_strobe_next = 1'b1;
                    paralelo_next    = is_comma ? 9'h000 : {1'b1, window_next};
                end
            end
            default: begin
                state_next     = SEARCH;
                bit_cnt_next   = 3'd0;
                comma_cnt_next = '0;
            end
        endcase

        active_next = (state_next == ACTIVE);
    end

    // State and registered outputs; reset discards any partial word.
    always_ff @(posedge clk8f) begin
        if (reset) begin
            state       <= SEARCH;
            window      <= '0;
            bit_cnt     <= 3'd0;
            comma_cnt   <= '0;
            paralelo    <= 9'h000;
            word_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_next;
            window      <= window_next;
            bit_cnt     <= bit_cnt_next;
            comma_cnt   <= comma_cnt_next;
            paralelo    <= paralelo_next;
            word_strobe <= word_strobe_next;
            active      <= active_next;
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: directed lock/data scenarios,
// a loopback of serialized words and a random bit stream, all compared
// against a behavioural receiver model.
module tb_serial_paralelo;

    localparam logic [7:0] T_COMMA = 8'hBC;
    localparam int         T_NUM   = 4;

    logic       clk8f = 1'b0;
    logic       reset = 1'b1;
    logic       serial = 1'b0;
    logic [8:0] paralelo;
    logic       word_strobe;
    logic       active;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int         m_n;
    int         m_align;
    int         m_commas;
    bit         m_locked;
    logic [7:0] m_win;
    logic [8:0] m_par;
    logic       m_stb;

    bit stim[$];

    serial_paralelo dut (
        .clk8f       (clk8f),
        .reset       (reset),
        .serial      (serial),
        .paralelo    (paralelo),
        .word_strobe (word_strobe),
        .active      (active)
    );

    always #5 clk8f = ~clk8f;

    // Receiver model: word boundaries are every 8th bit after the cycle where
    // an aligning comma was first seen.
    task automatic model_update(input bit b, input bit r);
        m_stb = 1'b0;
        if (r) begin
            m_n = 0; m_align = -1; m_commas = 0; m_locked = 0;
            m_win = 8'h00; m_par = 9'h000;
        end else begin
            m_n++;
            m_win = 8'((int'(m_win) * 2 + int'(b)) % 256);
            if (m_locked) begin
                if ((m_n - m_align) % 8 == 0) begin
                    m_stb = 1'b1;
                    m_par = (m_win == T_COMMA) ? 9'h000 : {1'b1, m_win};
                end
            end else if (m_align < 0) begin
                if (m_win == T_COMMA) begin
                    m_align  = m_n;
                    m_commas = 1;
                    if (m_commas >= T_NUM) m_locked = 1;
                end
            end else if ((m_n - m_align) % 8 == 0) begin
                if (m_win == T_COMMA) begin
                    m_commas++;
                    if (m_commas >= T_NUM) m_locked = 1;
                end else begin
                    m_align  = -1;
                    m_commas = 0;
                end
            end
        end
    endtask

    // Drive one bit across one clock edge, then sample 1 time unit later.
    task automatic step(input bit b, input bit r);
        serial = b;
        reset  = r;
        @(posedge clk8f);
        model_update(b, r);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) stim.push_back(w[i]);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(1)), 1'b1);
            checks++;
            if ({paralelo, word_strobe, active} !== 11'h000) begin
                failures++;
                $display("FAIL reset_outputs: got %h/%b/%b expected 000/0/0",
                         paralelo, word_strobe, active);
            end
        end
    endtask

    task automatic test_lock_and_data();
        step(1'b0, 1'b1);
        stim.delete();
        for (int i = 0; i < 4; i++) push_word(T_COMMA);
        push_word(8'hA5);
        push_word(T_COMMA);
        for (int k = 1; k <= 48; k++) begin
            step(stim[k-1], 1'b0);
            checks++;
            if (active !== (k >= 32)) begin
                failures++;
                $display("FAIL lock_active bit %0d: got %b expected %b", k, active, k >= 32);
            end
            checks++;
            if (word_strobe !== (k == 40 || k == 48)) begin
                failures++;
                $display("FAIL lock_strobe bit %0d: got %b expected %b", k, word_strobe,
                         (k == 40 || k == 48));
            end
            if (k >= 40 && k < 48) begin
                checks++;
                if (paralelo !== 9'h1A5) begin
                    failures++;
                    $display("FAIL data_a5 bit %0d: got %h expected 1a5", k, paralelo);
                end
            end
            if (k == 48) begin
                checks++;
                if (paralelo !== 9'h000) begin
                    failures++;
                    $display("FAIL idle_comma: got %h expected 000", paralelo);
                end
            end
        end
    endtask

    task automatic test_offset();
        step(1'b0, 1'b1);
        stim.delete();
        for (int i = 0; i < 3; i++) stim.push_back(1'($urandom_range(1)));
        for (int i = 0; i < 4; i++) push_word(T_COMMA);
        push_word(8'h3C);
        for (int k = 1; k <= 43; k++) begin
            step(stim[k-1], 1'b0);
            checks++;
            if (active !== (k >= 35) || word_strobe !== (k == 43)) begin
                failures++;
                $display("FAIL offset_lock bit %0d: got act=%b stb=%b expected act=%b stb=%b",
                         k, active, word_strobe, k >= 35, k == 43);
            end
        end
        checks++;
        if (paralelo !== 9'h13C) begin
            failures++;
            $display("FAIL offset_data: got %h expected 13c", paralelo);
        end
    endtask

    task automatic test_break();
        step(1'b0, 1'b1);
        stim.delete();
        push_word(T_COMMA);
        push_word(T_COMMA);
        push_word(8'h55);
        for (int i = 0; i < 4; i++) push_word(T_COMMA);
        push_word(8'h11);
        for (int k = 1; k <= 64; k++) begin
            step(stim[k-1], 1'b0);
            checks++;
            if (active !== (k >= 56) || word_strobe !== (k == 64)) begin
                failures++;
                $display("FAIL break_relock bit %0d: got act=%b stb=%b expected act=%b stb=%b",
                         k, active, word_strobe, k >= 56, k == 64);
            end
        end
        checks++;
        if (paralelo !== 9'h111) begin
            failures++;
            $display("FAIL break_data: got %h expected 111", paralelo);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1);
        stim.delete();
        for (int i = 0; i < 4; i++) push_word(T_COMMA);
        push_word(8'h5A);
        push_word(8'h77);
        for (int k = 1; k <= 43; k++) step(stim[k-1], 1'b0);
        checks++;
        if (paralelo !== 9'h15A || active !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: got %h act=%b expected 15a act=1", paralelo, active);
        end
        step(1'($urandom_range(1)), 1'b1);
        checks++;
        if ({paralelo, word_strobe, active} !== 11'h000) begin
            failures++;
            $display("FAIL midreset_clear: got %h/%b/%b expected 000/0/0",
                     paralelo, word_strobe, active);
        end
        stim.delete();
        for (int i = 0; i < 4; i++) push_word(T_COMMA);
        push_word(8'hC3);
        for (int k = 1; k <= 40; k++) begin
            step(stim[k-1], 1'b0);
            checks++;
            if (active !== (k >= 32) || word_strobe !== (k == 40)) begin
                failures++;
                $display("FAIL midreset_relock bit %0d: got act=%b stb=%b expected act=%b stb=%b",
                         k, active, word_strobe, k >= 32, k == 40);
            end
        end
        checks++;
        if (paralelo !== 9'h1C3) begin
            failures++;
            $display("FAIL midreset_data: got %h expected 1c3", paralelo);
        end
    endtask

    task automatic test_loopback();
        logic [8:0] expq[$];
        logic [7:0] w;
        logic [8:0] e;
        int         valid_rx;
        step(1'b0, 1'b1);
        stim.delete();
        valid_rx = 0;
        for (int i = 0; i < 4; i++) push_word(T_COMMA);
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < int'($urandom_range(2)); j++) begin
                push_word(T_COMMA);
                expq.push_back(9'h000);
            end
            do w = 8'($urandom); while (w == T_COMMA);
            push_word(w);
            expq.push_back({1'b1, w});
        end
        for (int k = 0; k < stim.size(); k++) begin
            step(stim[k], 1'b0);
            checks++;
            if ({paralelo, word_strobe, active} !== {m_par, m_stb, 1'(m_locked)}) begin
                failures++;
                $display("FAIL loop_model bit %0d: got %h/%b/%b expected %h/%b/%b", k,
                         paralelo, word_strobe, active, m_par, m_stb, m_locked);
            end
            if (word_strobe === 1'b1) begin
                e = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
                checks++;
                if (paralelo !== e) begin
                    failures++;
                    $display("FAIL loop_word bit %0d: got %h expected %h", k, paralelo, e);
                end
                if (paralelo[8] === 1'b1) valid_rx++;
            end
        end
        checks++;
        if (expq.size() != 0 || valid_rx != 256) begin
            failures++;
            $display("FAIL loop_count: got %0d valid, %0d left expected 256 valid, 0 left",
                     valid_rx, expq.size());
        end
    endtask

    task automatic test_random_stream();
        bit b;
        bit r;
        step(1'b0, 1'b1);
        for (int blk = 0; blk < 300; blk++) begin
            stim.delete();
            if ($urandom_range(2) != 0) push_word(T_COMMA);
            else push_word(8'($urandom));
            if ($urandom_range(3) == 0) stim.push_back(1'($urandom_range(1)));
            for (int k = 0; k < stim.size(); k++) begin
                b = stim[k];
                r = ($urandom_range(399) == 0);
                step(b, r);
                checks++;
                if ({paralelo, word_strobe, active} !== {m_par, m_stb, 1'(m_locked)}) begin
                    failures++;
                    $display("FAIL rand_model blk %0d: got %h/%b/%b expected %h/%b/%b", blk,
                             paralelo, word_strobe, active, m_par, m_stb, m_locked);
                end
            end
        end
    endtask

    initial begin
        model_update(1'b0, 1'b1);
        test_reset();
        test_lock_and_data();
        test_offset();
        test_break();
        test_reset_mid();
        test_loopback();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_paralelo.md
SERIAL_PARALELO -- requirements
Module: serial_paralelo

Interface
REQ-001 Parameter COMMA, default 8'hBC; idle/alignment character, sent MSB first.
REQ-002 Parameter NUM_COMMA, default 4; consecutive aligned commas required to declare lock.
REQ-003 clk8f  input  1  bit clock; all logic on posedge clk8f; one clock only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 serial  input  1  serial bit stream, 8-bit words, MSB first, one bit per clk8f cycle.
REQ-006 paralelo  output  9  recovered word; [8] valid, [7:0] data.
REQ-007 word_strobe  output  1  single-cycle pulse when paralelo is updated.
REQ-008 active  output  1  high while the receiver is locked to word boundaries.

Function
REQ-009 Block SHALL keep an 8-bit shift window; each cycle window_next = {window[6:0], serial}.
REQ-010 FSM SHALL have states SEARCH, SYNC, ACTIVE.
REQ-011 SEARCH: bit-by-bit compare of window_next against COMMA.
- Match: go to SYNC, comma_cnt=1, bit_cnt=0.
- No match: stay.
REQ-012 SYNC/ACTIVE: bit_cnt SHALL count 0..7 and wrap. A word boundary is the cycle with bit_cnt==7; the evaluated word is window_next.
REQ-013 SYNC, at boundary:
- Word==COMMA: comma_cnt+1; on reaching NUM_COMMA go to ACTIVE with active=1 on the same edge.
- Word!=COMMA: return to SEARCH, comma_cnt=0.
REQ-014 SYNC SHALL NOT update paralelo or pulse word_strobe.
REQ-015 ACTIVE, at every boundary: word_strobe=1 for one cycle; paralelo updated on the same edge.
- Word==COMMA: paralelo={1'b0,8'h00}.
- Otherwise: paralelo={1'b1,word}.
REQ-016 Latency: paralelo SHALL reflect a word on the same clk8f edge that samples its LSB (bit 0).
REQ-017 paralelo SHALL hold its value between boundaries; word_strobe=0 off-boundary.
REQ-018 ACTIVE SHALL persist until reset; data words equal to COMMA are not expected in payload.
REQ-019 The comma that completes lock SHALL NOT produce a strobe; the first strobe comes 8 cycles later.
REQ-020 comma_cnt SHALL saturate at NUM_COMMA; width is clog2(NUM_COMMA+1) bits.

Reset
REQ-021 reset=1 at posedge clk8f SHALL force:
- state=SEARCH, window=0, bit_cnt=0, comma_cnt=0;
- paralelo=9'h000, word_strobe=0, active=0.
REQ-022 reset mid-word or mid-lock SHALL discard partial data; the next word requires fresh comma search.
REQ-023 serial SHALL be ignored during cycles with reset=1.

Structure
REQ-024 Shared package SHALL hold COMMA, NUM_COMMA defaults, and the state encoding (SEARCH=2'd0, SYNC=2'd1, ACTIVE=2'd2).
REQ-025 No sub-module is required; all logic SHALL reside in serial_paralelo. The reference model is paralelo_serial looped back.

Verification
REQ-026 Reset, then 4x 0xBC aligned -> active=1 at bit 32; no word_strobe before bit 40.
REQ-027 Lock, then 0xA5 -> paralelo=9'h1A5 with strobe on the 8th bit of the word; then 0xBC -> paralelo=9'h000.
REQ-028 3 random bits, then 4x 0xBC -> lock at the comma boundary offset by 3; subsequent 0x3C -> 9'h13C.
REQ-029 2x 0xBC then 0x55 -> returns to SEARCH, active=0, comma_cnt=0; relock requires 4 new commas.
REQ-030 Reset asserted mid-word in ACTIVE -> all outputs 0 next edge; relock after 4 commas.
REQ-031 Loopback with the upstream serializer, 256 random valid words interleaved with idle -> every valid word is received in order, and idles produce valid=0.
